// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access-size encodings, FSM states
// and the natural-alignment check used when a request is accepted.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 64-bit little-endian doubleword: byte enables and
// shifted store data from size/offset, right-aligned zero-extended load data.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] rdword,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata
);
    logic [7:0]  mask;
    logic [63:0] rdata_sh;

    always_comb begin
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        be       = mask << addr_lo;
        wdata_sh = wdata << {addr_lo, 3'b000};
        rdata_sh = rdword >> {addr_lo, 3'b000};
        case (size)
            SZ_B:    rdata = {56'd0, rdata_sh[7:0]};
            SZ_H:    rdata = {48'd0, rdata_sh[15:0]};
            SZ_W:    rdata = {32'd0, rdata_sh[31:0]};
            default: rdata = rdata_sh;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait-state latency, then a
// response with load data or an error flag. DMEM_PERF_EN adds load/store counters.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states after acceptance
// RESP  | response presented, held until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_responder_if.slave bus
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] ld_count,
    output logic [31:0] st_count
`endif
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t      state, state_nxt;
    logic [3:0]  count, count_nxt;
    logic        enter_resp;
    logic        we_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q;
    logic        rsp_err_q;
    logic [63:0] rsp_rdata_q;
    logic        cur_we, cur_err;
    logic [1:0]  cur_size;
    logic [63:0] cur_addr, cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic [7:0]  be;
    logic [63:0] wdata_sh, rdata_al;
    logic [63:0] mem [DEPTH];

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // With no wait states RESP is entered on the accept edge, so the bus is used directly.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = bus.req_we;
            cur_size  = bus.req_size;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        cur_err = !is_aligned(cur_size, cur_addr[2:0]) || (cur_addr[63:3] >= 61'(DEPTH));
        cur_idx = cur_addr[IDX_W+2:3];
    end

    dmem_lane_align u_lane_align (
        .size     (cur_size),
        .addr_lo  (cur_addr[2:0]),
        .wdata    (cur_wdata),
        .rdword   (mem[cur_idx]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (rdata_al)
    );

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        count_nxt = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                count_nxt = count - 4'd1;
                if (count == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            addr_q      <= 64'd0;
            wdata_q     <= 64'd0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 64'd0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                rsp_err_q   <= cur_err;
                rsp_rdata_q <= (cur_err || cur_we) ? 64'd0 : rdata_al;
            end
        end
    end

    // Storage is deliberately not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[cur_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_count <= 32'd0;
            st_count <= 32'd0;
        end else if (bus.rsp_valid && bus.rsp_ready && !rsp_err_q) begin
            if (we_q) st_count <= st_count + 32'd1;
            else      ld_count <= ld_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// compared against a byte-array memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int W     = 2;

    logic clk = 1'b0;
    logic reset;

    dmem_responder_if bus ();

`ifdef DMEM_PERF_EN
    logic [31:0] ld_count, st_count;
`endif

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_PERF_EN
        ,
        .ld_count (ld_count),
        .st_count (st_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ref_ld = 0;
    int ref_st = 0;
    logic [7:0] ref_mem [DEPTH*8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [63:0] addr);
        longint unsigned nb;
        nb = 64'd1 << size;
        return ((addr % nb) != 0) || (addr >= 64'(DEPTH*8));
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] size, input logic [63:0] addr);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < (1 << size); i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [63:0] addr, input logic [63:0] wdata);
        for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    endtask

    task automatic drive_junk();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_D;
        bus.req_addr  = 64'($urandom_range(0, DEPTH-1)) << 3;
        bus.req_wdata = {$urandom, $urandom};
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input int bp, output logic [63:0] rdata);
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic [63:0] held;
        int          lat;
        exp_err   = ref_err(size, addr);
        exp_rdata = (exp_err || we) ? 64'd0 : ref_load(size, addr);
        chk({tag, ":req_ready_idle"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        drive_junk();
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ":latency"}, 64'(lat), 64'(W + 1));
        chk({tag, ":rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
        chk({tag, ":rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        rdata = bus.rsp_rdata;
        held  = bus.rsp_rdata;
        for (int c = 0; c < bp; c++) begin
            @(posedge clk); #1;
            chk({tag, ":bp_valid"}, 64'(bus.rsp_valid), 64'd1);
            chk({tag, ":bp_rdata"}, bus.rsp_rdata, held);
            chk({tag, ":bp_req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, ":post_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, ":post_req_ready"}, 64'(bus.req_ready), 64'd1);
        if (!exp_err) begin
            if (we) begin
                ref_store(size, addr, wdata);
                ref_st++;
            end else begin
                ref_ld++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [63:0] a;
        logic [63:0] d;
        logic [1:0]  sz;
        int          lat;

        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = SZ_B;
        bus.req_addr  = 64'd0;
        bus.req_wdata = 64'd0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset:req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset:rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset:rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("reset:rsp_err", 64'(bus.rsp_err), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++)
            do_req("init", 1'b1, SZ_D, 64'(i * 8), {$urandom, $urandom}, 0, r);

        do_req("rt_store", 1'b1, SZ_D, 64'h10, 64'h1122334455667788, 0, r);
        do_req("rt_load", 1'b0, SZ_D, 64'h10, 64'd0, 0, r);
        chk("rt_const", r, 64'h1122334455667788);

        d = ({$urandom, $urandom} & ~64'hFF) | 64'hAB;
        do_req("lane_store_b", 1'b1, SZ_B, 64'h13, d, 0, r);
        do_req("lane_load_d", 1'b0, SZ_D, 64'h10, 64'd0, 0, r);
        chk("lane_const_d", r, 64'h11223344AB667788);
        do_req("lane_load_h", 1'b0, SZ_H, 64'h12, 64'd0, 0, r);
        chk("lane_const_h", r, 64'h000000000000AB66);

        do_req("err_misalign", 1'b0, SZ_W, 64'h06, 64'd0, 0, r);
        do_req("err_range_st", 1'b1, SZ_D, 64'(8 * DEPTH), {$urandom, $urandom}, 0, r);
        do_req("err_idx0_load", 1'b0, SZ_D, 64'h0, 64'd0, 0, r);

        do_req("backpressure", 1'b0, SZ_D, 64'h10, 64'd0, 5, r);

        // Reset while a store is still waiting: must be discarded.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_B;
        bus.req_addr  = 64'h20;
        bus.req_wdata = 64'hFF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("abort_wait:busy", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("abort_wait:rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_wait:req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_req("abort_wait_load", 1'b0, SZ_B, 64'h20, 64'd0, 0, r);

        // Reset while a store sits in RESP: the write has already committed.
        d = {$urandom, $urandom};
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_D;
        bus.req_addr  = 64'h28;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("abort_resp:latency", 64'(lat), 64'(W + 1));
        reset = 1'b0;
        #1;
        chk("abort_resp:rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_resp:req_ready", 64'(bus.req_ready), 64'd1);
        chk("abort_resp:rsp_rdata", bus.rsp_rdata, 64'd0);
        ref_store(SZ_D, 64'h28, d);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_req("abort_resp_load", 1'b0, SZ_D, 64'h28, 64'd0, 0, r);
        chk("abort_resp_const", r, d);

        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, DEPTH * 8 - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            if ($urandom_range(0, 9) == 0) a = a + 64'(DEPTH * 8);
            do_req("rand", 1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom},
                   int'($urandom_range(0, 2)), r);
        end

        for (int i = 0; i < DEPTH; i++)
            do_req("final_scan", 1'b0, SZ_D, 64'(i * 8), 64'd0, 0, r);

`ifdef DMEM_PERF_EN
        chk("perf:ld_count", 64'(ld_count), 64'(ref_ld));
        chk("perf:st_count", 64'(st_count), 64'(ref_st));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
